// File: rtl/sample_buffer_read_arbiter_if.sv
// ============================================================================
// Module  : sample_buffer_read_arbiter_if
// Brief   : RAM read side and two-consumer bus of the sample buffer read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sample_buffer_read_arbiter_if #(
  parameter int unsigned DATA_W = 36
);
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_valid_i;
  logic              ram_ready_o;
  logic              ram_buffer_ready_i;
  logic [1:0]        req_i;
  logic [1:0]        gnt_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        valid_o;
  logic [1:0]        ready_i;
  logic              last_o;
  logic              busy_o;
  logic              abort_o;

  // Arbiter side
  modport slave (
    input  ram_data_i, ram_valid_i, ram_buffer_ready_i, req_i, ready_i,
    output ram_ready_o, gnt_o, data_o, valid_o, last_o, busy_o, abort_o
  );

  // RAM + consumers side
  modport master (
    output ram_data_i, ram_valid_i, ram_buffer_ready_i, req_i, ready_i,
    input  ram_ready_o, gnt_o, data_o, valid_o, last_o, busy_o, abort_o
  );
endinterface

`default_nettype wire

// File: rtl/sample_buffer_read_arbiter.sv
// ============================================================================
// Module  : sample_buffer_read_arbiter
// Brief   : Round-robin burst arbiter sharing the sample RAM read port between
//           two consumers. Optional stall timeout via macro STALL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_buffer_read_arbiter #(
  parameter int unsigned DATA_W      = 36,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input wire                           clk_i,
  input wire                           rst_ni,
  sample_buffer_read_arbiter_if.slave  bus
);

  localparam int unsigned          c_CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_gnt,   w_gnt_nxt;
  logic                 r_win,   w_win_nxt;
  logic                 r_ptr,   w_ptr_nxt;
  logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;

  logic                 w_ram_ready;
  logic [1:0]           w_valid;
  logic                 w_last;
  logic                 w_hs;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned          c_STALL_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT_CYC - 1);

  logic [c_STALL_W-1:0] r_stall, w_stall_nxt;
  logic                 w_stall;
  logic                 w_abort;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_win   <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
`ifdef STALL_TIMEOUT_EN
      r_stall <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_win   <= w_win_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef STALL_TIMEOUT_EN
      r_stall <= w_stall_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_win_nxt   = r_win;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ram_ready = 1'b0;
    w_valid     = 2'b00;
    w_last      = 1'b0;
    w_hs        = 1'b0;
`ifdef STALL_TIMEOUT_EN
    w_stall_nxt = r_stall;
    w_stall     = 1'b0;
    w_abort     = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.ram_buffer_ready_i && |bus.req_i) begin
          // Contention goes to the pointer; a lone requester wins outright
          w_win_nxt   = (bus.req_i == 2'b11) ? r_ptr : bus.req_i[1];
          w_gnt_nxt   = w_win_nxt ? 2'b10 : 2'b01;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
`ifdef STALL_TIMEOUT_EN
          w_stall_nxt = '0;
`endif
        end
      end

      S_BURST: begin
        w_ram_ready    = bus.ready_i[r_win];
        w_valid[r_win] = bus.ram_valid_i;
        w_hs           = bus.ram_valid_i && w_ram_ready;
`ifdef STALL_TIMEOUT_EN
        w_stall        = bus.ram_valid_i && !bus.ready_i[r_win];
`endif
        if (w_hs) begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
`ifdef STALL_TIMEOUT_EN
          w_stall_nxt = '0;
`endif
          if (r_cnt == c_LAST) begin
            w_last      = 1'b1;
            w_gnt_nxt   = 2'b00;
            w_state_nxt = S_RELEASE;
          end
        end
`ifdef STALL_TIMEOUT_EN
        else if (w_stall && (r_stall == c_STALL_LAST)) begin
          w_abort     = 1'b1;
          w_gnt_nxt   = 2'b00;
          w_state_nxt = S_RELEASE;
        end
`endif
        else if (!bus.req_i[r_win]) begin
          w_gnt_nxt   = 2'b00;
          w_state_nxt = S_RELEASE;
        end
`ifdef STALL_TIMEOUT_EN
        else if (w_stall) begin
          w_stall_nxt = r_stall + c_STALL_W'(1);
        end
`endif
      end

      S_RELEASE: begin
        w_cnt_nxt   = '0;
        w_ptr_nxt   = ~r_win;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.ram_ready_o = w_ram_ready;
  assign bus.valid_o     = w_valid;
  assign bus.last_o      = w_last;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.data_o      = bus.ram_data_i;

`ifdef STALL_TIMEOUT_EN
  assign bus.abort_o = w_abort;
`else
  // Without the timeout a stalled consumer keeps the port indefinitely
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC != 0);
  assign bus.abort_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_buffer_read_arbiter.sv
// Self-checking bench for sample_buffer_read_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
`default_nettype none

module tb_sample_buffer_read_arbiter;
  localparam int DW = 36;
  localparam int BL = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_buffer_read_arbiter_if #(.DATA_W(DW)) bus ();

  sample_buffer_read_arbiter #(
    .DATA_W(DW), .BURST_LEN(BL), .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: owner / words / pointer ----------------
  int   m_owner = -1;   // consumer holding the port, -1 none
  bit   m_rel   = 0;    // one release cycle pending
  int   m_rel_from;
  int   m_words;
  int   m_ptr   = 0;
  int   m_stall;

  initial begin : compare
    logic [1:0] e_gnt, e_valid;
    logic       e_rr, e_last, e_busy, e_abort;
    bit         hs, stall;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_rel = 0; m_ptr = 0; m_words = 0; m_stall = 0;
        chk("reset_outputs",
            {bus.gnt_o, bus.valid_o, bus.ram_ready_o, bus.last_o, bus.busy_o, bus.abort_o}, 8'h00);
      end else begin
        e_gnt = 2'b00; e_valid = 2'b00; e_rr = 1'b0; e_last = 1'b0; e_abort = 1'b0;
        hs = 0; stall = 0;
        e_busy = (m_owner >= 0) || m_rel;
        if (m_owner >= 0) begin
          e_gnt            = (m_owner == 0) ? 2'b01 : 2'b10;
          e_rr             = bus.ready_i[m_owner];
          e_valid[m_owner] = bus.ram_valid_i;
          hs               = bus.ram_valid_i && bus.ready_i[m_owner];
          stall            = bus.ram_valid_i && !bus.ready_i[m_owner];
          e_last           = hs && (m_words == BL - 1);
`ifdef STALL_TIMEOUT_EN
          e_abort          = stall && (m_stall == TO - 1);
`endif
        end
        chk("outputs",
            {bus.gnt_o, bus.valid_o, bus.ram_ready_o, bus.last_o, bus.busy_o, bus.abort_o},
            {e_gnt, e_valid, e_rr, e_last, e_busy, e_abort});
        chk("data_passthru", 64'(bus.data_o), 64'(bus.ram_data_i));

        // advance model to the next cycle
        if (m_rel) begin
          m_ptr = 1 - m_rel_from;
          m_rel = 0;
        end else if (m_owner >= 0) begin
          if (hs) begin
            m_words++;
            m_stall = 0;
          end else if (stall && !e_abort && bus.req_i[m_owner]) begin
            m_stall++;
          end
          if ((hs && m_words == BL) || (!hs && (e_abort || !bus.req_i[m_owner]))) begin
            m_rel = 1; m_rel_from = m_owner; m_owner = -1; m_words = 0;
          end
        end else if (bus.ram_buffer_ready_i && bus.req_i != 2'b00) begin
          m_owner = (bus.req_i == 2'b11) ? m_ptr : (bus.req_i == 2'b01 ? 0 : 1);
          m_words = 0;
          m_stall = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] req, input logic bufr, input logic [1:0] rdy,
                       input logic rv, input logic [DW-1:0] d);
    bus.req_i = req; bus.ram_buffer_ready_i = bufr; bus.ready_i = rdy;
    bus.ram_valid_i = rv; bus.ram_data_i = d;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 2'b00, 1'b0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] seq[$];
  logic [1:0] exp2 [5];
  int   k;
  bit   found, ok;
  int   hit_c;

  initial begin
    drive(2'b00, 1'b0, 2'b00, 1'b0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt", bus.gnt_o, 2'b00);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_abort", bus.abort_o, 1'b0);
    do_reset();

    // 1: single requester, full burst of 4
    drive(2'b01, 1'b1, 2'b11, 1'b1, '0);
    k = 0;
    @(negedge clk); chk("t1_gnt_qual", bus.gnt_o, 2'b00);
    step();         @(negedge clk); chk("t1_gnt_rise", bus.gnt_o, 2'b01);
    for (int c = 0; c < 12 && k < 4; c++) begin
      if (bus.valid_o[0] && bus.ram_ready_o) begin
        chk("t1_data", 64'(bus.data_o), 64'(k));
        chk("t1_last", bus.last_o, (k == 3));
        k++;
      end
      step();
      bus.ram_data_i = DW'(k);
      if (k < 4) @(negedge clk);
    end
    chk("t1_words", k, 4);
    bus.req_i = 2'b00;
    @(negedge clk); chk("t1_gap_gnt", bus.gnt_o, 2'b00);
    step();         @(negedge clk); chk("t1_idle_busy", bus.busy_o, 1'b0);

    // 2: both requesting from reset, round-robin
    do_reset();
    drive(2'b11, 1'b1, 2'b11, 1'b1, '0);
    seq.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((seq.size() == 0 && bus.gnt_o != 2'b00) ||
          (seq.size() != 0 && bus.gnt_o != seq[seq.size()-1]))
        seq.push_back(bus.gnt_o);
      step();
    end
    exp2 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    chk("t2_seq_len_ge5", (seq.size() >= 5), 1'b1);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("t2_gnt_seq", seq[i], exp2[i]);

    // 3: buffer not ready blocks grants
    do_reset();
    drive(2'b01, 1'b0, 2'b11, 1'b1, '0);
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.gnt_o != 2'b00) ok = 0;
      step();
    end
    chk("t3_blocked", ok, 1'b1);
    bus.ram_buffer_ready_i = 1'b1;
    @(negedge clk); chk("t3_gnt_qual", bus.gnt_o, 2'b00);
    step();
    bus.ready_i = 2'b01;
    bus.ram_data_i = '0;

    // 4: ready_i[0] toggling; words delivered in order
    @(negedge clk); chk("t3_gnt_rise", bus.gnt_o, 2'b01);
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      chk("t4_rr_mirror", bus.ram_ready_o, bus.ready_i[0]);
      if (bus.valid_o[0] && bus.ram_ready_o) begin
        chk("t4_data", 64'(bus.data_o), 64'(k));
        chk("t4_last", bus.last_o, (k == 3));
        k++;
      end
      step();
      bus.ready_i[0] = ~bus.ready_i[0];
      bus.ram_data_i = DW'(k);
      if (k < 4) @(negedge clk);
    end
    chk("t4_words", k, 4);

    // 5: early release, then async reset mid-burst
    do_reset();
    drive(2'b11, 1'b1, 2'b11, 1'b1, '0);
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge clk);
      if (bus.valid_o[0] && bus.ram_ready_o) k++;
      step();
    end
    bus.req_i = 2'b10;
    bus.ram_valid_i = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_release", {bus.gnt_o, bus.busy_o}, 3'b001);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      if (bus.gnt_o == 2'b10) found = 1;
    end
    chk("t5_next_grant", bus.gnt_o, 2'b10);
    bus.ram_valid_i = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("t5_async_reset",
           {bus.gnt_o, bus.valid_o, bus.ram_ready_o, bus.last_o, bus.busy_o}, 7'h00);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    bus.req_i = 2'b11;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.gnt_o != 2'b00) found = 1; else step();
    end
    chk("t5_first_after_reset", bus.gnt_o, 2'b01);
    step();

    // 6: stalled consumer
    do_reset();
    drive(2'b01, 1'b1, 2'b00, 1'b1, '0);
`ifdef STALL_TIMEOUT_EN
    found = 0; hit_c = -1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.abort_o) begin found = 1; hit_c = c; end
      step();
    end
    chk("t6_abort_seen", found, 1'b1);
    chk("t6_abort_cycle", hit_c, 16);
    @(negedge clk); chk("t6_gnt_after", bus.gnt_o, 2'b00);
    step();
`else
    ok = 1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c >= 1 && bus.gnt_o != 2'b01) ok = 0;
      if (bus.abort_o) ok = 0;
      step();
    end
    chk("t6_hold_no_abort", ok, 1'b1);
`endif

    // random traffic, checked every cycle by the model
    do_reset();
    drive(2'b00, 1'b1, 2'b11, 1'b1, '0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req_i = 2'($urandom_range(0, 3));
      bus.ram_buffer_ready_i = ($urandom_range(0, 3) != 0);
      bus.ready_i            = 2'($urandom_range(0, 3));
      bus.ram_valid_i        = ($urandom_range(0, 3) != 0);
      bus.ram_data_i         = DW'({$urandom, $urandom});
      step();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
